fsb_echo_node: RTL and testbench
================================

# fsb_echo_node

FSB slave endpoint that sits directly downstream of the AXI-Lite→FSB adapter. It consumes request packets from the adapter's FSB output and returns response packets on the adapter's FSB input. Echo and count-query packets are answered through an internal FIFO; unknown opcodes are dropped and counted. It lets host software exercise the full OCL→FSB→OCL path before real FSB clients exist.

## Interface
Parameters:
- fsb_width_p, "inv", FSB packet width; must be ≥ 48 (80 in the shipped design)
- els_p, 4, response FIFO depth; power of two, ≥ 2

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  reset; synchronous, active-low
- v_i  in  1  request valid, driven by the adapter
- data_i  in  fsb_width_p  request packet
- ready_o  out  1  node can accept a request this cycle
- v_o  out  1  response valid, driven toward the adapter
- data_o  out  fsb_width_p  response packet
- yumi_i  in  1  adapter consumes the response this cycle; asserted only when v_o=1
- rx_count_o  out  32  accepted valid-opcode requests
- drop_count_o  out  32  accepted unknown-opcode requests

## Operation
- Opcode field: data_i[fsb_width_p-1 -: 8]. Payload field: all lower bits.
- Accept occurs when v_i & ready_o. ready_o = ~full. ready_o does not depend on v_i or yumi_i.
- Handling of an accepted packet by opcode:
  - 8'h01 ECHO: enqueue {8'h81, payload unchanged}; rx_count += 1.
  - 8'h02 COUNT: rx_count += 1; enqueue {8'h82, zeros, new rx_count[31:0]}. The reported value includes this query.
  - Any other opcode: drop_count += 1. Nothing is enqueued. The packet is still accepted only when ready_o=1.
- Counters wrap modulo 2^32 and never saturate.
- FIFO: els_p entries, 1 write and 1 read per cycle, in-order.
  - Read and write pointers are $clog2(els_p) bits and wrap naturally.
  - A separate occupancy counter of $clog2(els_p)+1 bits provides full and empty.
- v_o = ~empty. data_o = head entry. Dequeue occurs on yumi_i.
- Dequeue and enqueue in the same cycle leave occupancy unchanged.
  - This is legal at any occupancy where ready_o=1.
  - When full, ready_o=0, so no enqueue occurs even if yumi_i=1 in that cycle. There is no bypass.

## Timing
- Reset (resetn_i=0 at a rising edge):
  - Pointers, occupancy and both counters are cleared.
  - Outputs while in reset: ready_o=0, v_o=0, data_o=0, rx_count_o=0, drop_count_o=0.
- First cycle after resetn_i returns high: ready_o=1, v_o=0.
- Reset mid-operation discards all queued responses. Partial state is never preserved.
- Request accepted at edge N:
  - The response is visible on v_o/data_o after edge N, i.e. in cycle N+1, when the FIFO was empty. Latency is 1 cycle.
  - Counters update at edge N and are visible on rx_count_o/drop_count_o in cycle N+1.
- Throughput: 1 request/cycle sustained while yumi_i keeps pace.
- Full transition: with els_p entries queued, ready_o drops in the same cycle the FIFO becomes full. It rises the cycle after the first yumi_i.
- data_o is held stable while v_o=1 and yumi_i=0.

## Structure
- Shared package fsb_echo_pkg:
  - Opcode constants: ECHO_OP=8'h01, COUNT_OP=8'h02, ECHO_RSP=8'h81, COUNT_RSP=8'h82.
  - Opcode field width constant = 8.
- Sub-module fsb_echo_fifo: parameterised els_p × width, with ports v_i/data_i/ready_o and v_o/data_o/yumi_i. It holds the pointers and the occupancy counter.
- The top level holds opcode decode, response formatting and both counters.

## Test plan
- Reset: hold resetn_i=0 for 3 cycles, then release → ready_o=0 and v_o=0 during reset; ready_o=1 and v_o=0 on the first cycle after release; both counters 0.
- Single echo: send data_i={8'h01, 72'hAB_CDEF} with yumi_i tied to v_o → one cycle later, v_o=1 with data_o={8'h81, 72'hAB_CDEF}; rx_count_o=1.
- Count query: send ECHO, ECHO, COUNT back-to-back → responses in order 81, 81, then {8'h82, 0, 32'd3}; rx_count_o=3.
- Drop: send opcode 8'h7F → no response; drop_count_o=1; rx_count_o unchanged.
- Backpressure and full:
  - Hold yumi_i=0 and send 5 echoes with els_p=4 → 4 accepted; ready_o=0 in the cycle after the 4th accept; the 5th request is held by the adapter.
  - Then pulse yumi_i → ready_o=1 the next cycle; responses drain in order with no duplication or loss.
- Wrap and mid-reset:
  - Force rx_count to 32'hFFFF_FFFF, then send COUNT → response payload 0; rx_count_o=0.
  - Separately, assert resetn_i=0 with 3 entries queued → v_o=0 after the edge and the queued responses are never emitted.

Source files
------------

// File: rtl/fsb_echo_pkg.sv
// rtl/fsb_echo_pkg.sv - opcode constants shared by the FSB echo node
package fsb_echo_pkg;

  localparam int OP_W = 8;

  localparam logic [OP_W-1:0] ECHO_OP   = 8'h01;
  localparam logic [OP_W-1:0] COUNT_OP  = 8'h02;
  localparam logic [OP_W-1:0] ECHO_RSP  = 8'h81;
  localparam logic [OP_W-1:0] COUNT_RSP = 8'h82;

endpackage

// File: rtl/fsb_echo_fifo.sv
// rtl/fsb_echo_fifo.sv - in-order response queue with valid/ready in, valid/yumi out
module fsb_echo_fifo #(
  parameter int width_p = 80,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp:0]   els_lp     = (ptr_w_lp + 1)'(els_p);
  localparam logic [ptr_w_lp:0]   cnt_one_lp = (ptr_w_lp + 1)'(1);
  localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [ptr_w_lp:0]   count_r, count_n;
  logic                full, empty, enq, deq;

  assign full    = (count_r == els_lp);
  assign empty   = (count_r == '0);
  // Outputs are forced quiet while reset is held, not just after the reset edge.
  assign ready_o = resetn_i & ~full;
  assign v_o     = resetn_i & ~empty;
  assign data_o  = v_o ? mem[rd_ptr_r] : '0;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    count_n = count_r;
    case ({enq, deq})
      2'b10:   count_n = count_r + cnt_one_lp;
      2'b01:   count_n = count_r - cnt_one_lp;
      default: count_n = count_r;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + ptr_one_lp;
      if (deq) rd_ptr_r <= rd_ptr_r + ptr_one_lp;
      count_r <= count_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/fsb_echo_node.sv
// rtl/fsb_echo_node.sv - FSB slave that echoes packets and answers count queries
module fsb_echo_node
  import fsb_echo_pkg::*;
#(
  parameter int fsb_width_p = 80,
  parameter int els_p       = 4
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic                   v_i,
  input  logic [fsb_width_p-1:0] data_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [fsb_width_p-1:0] data_o,
  input  logic                   yumi_i,
  output logic [31:0]            rx_count_o,
  output logic [31:0]            drop_count_o
);

  logic [OP_W-1:0]        op;
  logic                   is_echo, is_count, is_known, accept, fifo_ready;
  logic [31:0]            rx_count_r, drop_count_r, rx_next;
  logic [fsb_width_p-1:0] rsp;

  assign op       = data_i[fsb_width_p-1 -: OP_W];
  assign is_echo  = (op == ECHO_OP);
  assign is_count = (op == COUNT_OP);
  assign is_known = is_echo | is_count;
  assign accept   = v_i & fifo_ready;
  assign ready_o  = fifo_ready;
  assign rx_next  = rx_count_r + 32'd1;

  // A count reply reports the counter including the query itself.
  always_comb begin
    rsp = data_i;
    rsp[fsb_width_p-1 -: OP_W] = ECHO_RSP;
    if (is_count) begin
      rsp = '0;
      rsp[fsb_width_p-1 -: OP_W] = COUNT_RSP;
      rsp[31:0] = rx_next;
    end
  end

  fsb_echo_fifo #(
    .width_p(fsb_width_p),
    .els_p  (els_p)
  ) rsp_fifo (
    .clk_i   (clk_i),
    .resetn_i(resetn_i),
    .v_i     (v_i & is_known),
    .data_i  (rsp),
    .ready_o (fifo_ready),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i)
  );

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rx_count_r   <= '0;
      drop_count_r <= '0;
    end else if (accept) begin
      if (is_known) rx_count_r   <= rx_next;
      else          drop_count_r <= drop_count_r + 32'd1;
    end
  end

  assign rx_count_o   = resetn_i ? rx_count_r   : '0;
  assign drop_count_o = resetn_i ? drop_count_r : '0;

endmodule

// File: tb/tb_fsb_echo_node.sv
// tb/tb_fsb_echo_node.sv - directed self-checking bench for fsb_echo_node
module tb_fsb_echo_node;

  logic        clk = 1'b0;
  logic        resetn;
  logic        v_i;
  logic [79:0] data_i;
  logic        ready_o;
  logic        v_o;
  logic [79:0] data_o;
  logic        yumi_i;
  logic [31:0] rx_count_o;
  logic [31:0] drop_count_o;

  int checks = 0;
  int errors = 0;

  fsb_echo_node #(
    .fsb_width_p(80),
    .els_p      (4)
  ) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .v_i         (v_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i),
    .rx_count_o  (rx_count_o),
    .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [79:0] pkt(input logic [7:0] op, input logic [71:0] pl);
    return {op, pl};
  endfunction

  initial begin
    resetn = 1'b0;
    v_i    = 1'b0;
    data_i = '0;
    yumi_i = 1'b0;
    @(negedge clk);

    // Reset held for 3 cycles
    tick; tick; tick;
    check("rst_ready", ready_o, 0);
    check("rst_v", v_o, 0);
    check("rst_data", data_o, 0);
    resetn = 1'b1;
    #1;
    check("post_rst_ready", ready_o, 1);
    check("post_rst_v", v_o, 0);
    check("post_rst_rx", rx_count_o, 0);
    check("post_rst_drop", drop_count_o, 0);

    // Single echo
    v_i = 1'b1; data_i = pkt(8'h01, 72'hAB_CDEF);
    tick;
    v_i = 1'b0;
    check("echo_v", v_o, 1);
    check("echo_data", data_o, pkt(8'h81, 72'hAB_CDEF));
    check("echo_rx", rx_count_o, 1);
    yumi_i = 1'b1; tick; yumi_i = 1'b0;
    check("echo_drained", v_o, 0);

    // ECHO, ECHO, COUNT back-to-back: rx goes 1 -> 4
    v_i = 1'b1; data_i = pkt(8'h01, 72'h11); tick;
    data_i = pkt(8'h01, 72'h22); tick;
    data_i = pkt(8'h02, 72'h5555); tick;
    v_i = 1'b0;
    check("cq_rx", rx_count_o, 4);
    check("cq_rsp0", data_o, pkt(8'h81, 72'h11));
    yumi_i = 1'b1; tick;
    check("cq_rsp1", data_o, pkt(8'h81, 72'h22));
    tick;
    check("cq_rsp2", data_o, pkt(8'h82, 72'd4));
    tick; yumi_i = 1'b0;
    check("cq_empty", v_o, 0);

    // Unknown opcode is dropped
    v_i = 1'b1; data_i = pkt(8'h7F, 72'h99); tick; v_i = 1'b0;
    check("drop_v", v_o, 0);
    check("drop_cnt", drop_count_o, 1);
    check("drop_rx", rx_count_o, 4);

    // Backpressure: 4 accepted, 5th held by the adapter
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; data_i = pkt(8'h01, 72'h100 + 72'(i));
      if (i == 3) begin
        #1;
        check("bp_ready_before_full", ready_o, 1);
      end
      tick;
    end
    check("bp_full_ready", ready_o, 0);
    check("bp_head", data_o, pkt(8'h81, 72'h100));
    data_i = pkt(8'h01, 72'h104);
    tick; tick;
    check("bp_still_full", ready_o, 0);
    check("bp_rx", rx_count_o, 8);
    yumi_i = 1'b1; tick; yumi_i = 1'b0;
    check("bp_ready_after_yumi", ready_o, 1);
    check("bp_rx_no_enq_when_full", rx_count_o, 8);
    tick;
    v_i = 1'b0;
    check("bp_fifth_rx", rx_count_o, 9);
    check("bp_full_again", ready_o, 0);
    yumi_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("bp_drain%0d", i), data_o, pkt(8'h81, 72'h100 + 72'(i)));
      tick;
    end
    yumi_i = 1'b0;
    check("bp_drained", v_o, 0);

    // Counter wrap
    force dut.rx_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.rx_count_r;
    check("wrap_pre", rx_count_o, 32'hFFFF_FFFF);
    v_i = 1'b1; data_i = pkt(8'h02, 72'h0); tick; v_i = 1'b0;
    check("wrap_rx", rx_count_o, 0);
    check("wrap_rsp", data_o, pkt(8'h82, 72'h0));
    yumi_i = 1'b1; tick; yumi_i = 1'b0;

    // Mid-operation reset with 3 queued responses
    v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = pkt(8'h01, 72'h200 + 72'(i));
      tick;
    end
    v_i = 1'b0;
    check("mr_queued", v_o, 1);
    resetn = 1'b0; tick;
    check("mr_v", v_o, 0);
    check("mr_ready", ready_o, 0);
    check("mr_rx", rx_count_o, 0);
    resetn = 1'b1;
    #1;
    check("mr_ready_release", ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mr_quiet%0d", i), v_o, 0);
      tick;
    end
    v_i = 1'b1; data_i = pkt(8'h01, 72'h3C3C); tick; v_i = 1'b0;
    check("mr_fresh_rsp", data_o, pkt(8'h81, 72'h3C3C));
    check("mr_fresh_rx", rx_count_o, 1);
    check("mr_fresh_drop", drop_count_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
